// File: rtl/uart_pkg.sv
// Shared types and defaults for the round-robin uart_tx arbiter slice.
package uart_pkg;

  localparam int DEF_DATAWIDTH    = 8;
  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_BUSY_TIMEOUT = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotate-priority picker: first requester after ptr_i, optionally
// restricted to a single locked index.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int IDXW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDXW-1:0]    ptr_i,
  input  logic               lock_en_i,
  input  logic [IDXW-1:0]    lock_idx_i,
  output logic [IDXW-1:0]    idx_o,
  output logic               found_o
);

  int              cand;
  logic [IDXW-1:0] cand_idx;

  // Scan starts one past the pointer so the previous winner has lowest priority.
  always_comb begin
    idx_o    = '0;
    found_o  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(ptr_i) + k) % NUM_REQ;
      cand_idx = IDXW'(cand);
      if (!found_o && req_i[cand_idx] && (!lock_en_i || (lock_idx_i == cand_idx))) begin
        found_o = 1'b1;
        idx_o   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx serializer among NUM_REQ byte
// producers, with optional packet lock and a busy-timeout recovery path.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int DATAWIDTH    = DEF_DATAWIDTH,
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
  localparam int IDXW = $clog2(NUM_REQ),
  localparam int CNTW = $clog2(BUSY_TIMEOUT + 1)
) (
  input  logic                         clk,
  input  logic                         rst_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  input  logic [NUM_REQ*DATAWIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]           req_last_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  output logic                         tx_start_o,
  output logic [DATAWIDTH-1:0]         tx_data_o,
  input  logic                         tx_done_i,
  output logic [IDXW-1:0]              grant_o,
  output logic                         busy_o,
  output logic                         err_o
);

  arb_state_t           state_q, state_d;
  logic                 lock_en_q, lock_en_d;
  logic [IDXW-1:0]      lock_idx_q, lock_idx_d;
  logic [IDXW-1:0]      ptr_q, ptr_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic [DATAWIDTH-1:0] data_q, data_d;
  logic [IDXW-1:0]      grant_q, grant_d;

  logic [NUM_REQ-1:0]   ready_c;
  logic                 start_c;
  logic                 err_c;
  logic [IDXW-1:0]      win_idx;
  logic                 win_found;
  logic [DATAWIDTH-1:0] win_data;

  uart_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req_i     (req_valid_i),
    .ptr_i     (ptr_q),
    .lock_en_i (lock_en_q),
    .lock_idx_i(lock_idx_q),
    .idx_o     (win_idx),
    .found_o   (win_found)
  );

  assign win_data = req_data_i[int'(win_idx)*DATAWIDTH +: DATAWIDTH];

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      lock_en_q  <= 1'b0;
      lock_idx_q <= '0;
      ptr_q      <= IDXW'(NUM_REQ - 1);
      cnt_q      <= '0;
      data_q     <= '0;
      grant_q    <= '0;
    end else begin
      state_q    <= state_d;
      lock_en_q  <= lock_en_d;
      lock_idx_q <= lock_idx_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      grant_q    <= grant_d;
    end
  end

  // The counter stops at BUSY_TIMEOUT, which is what makes it saturate.
  always_comb begin
    state_d    = state_q;
    lock_en_d  = lock_en_q;
    lock_idx_d = lock_idx_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    grant_d    = grant_q;
    ready_c    = '0;
    start_c    = 1'b0;
    err_c      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_found && tx_done_i) begin
          ready_c[win_idx] = 1'b1;
          data_d           = win_data;
          grant_d          = win_idx;
          ptr_d            = win_idx;
          if (req_last_i[win_idx]) begin
            lock_en_d = 1'b0;
          end else begin
            lock_en_d  = 1'b1;
            lock_idx_d = win_idx;
          end
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        start_c = 1'b1;
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!tx_done_i) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q >= CNTW'(BUSY_TIMEOUT)) begin
          err_c     = 1'b1;
          lock_en_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (tx_done_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Accept pulses are Mealy, so hold them off while reset is asserted.
  assign req_ready_o = rst_i ? '0 : ready_c;
  assign tx_start_o  = start_c;
  assign tx_data_o   = data_q;
  assign grant_o     = grant_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign err_o       = err_c;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural serializer stub
// and a round-robin/lock reference model.
module tb_uart_tx_arbiter;

  localparam int DW  = 8;
  localparam int N   = 4;
  localparam int BT  = 4;
  localparam int CPB = 4;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [N-1:0]  req_valid_i;
  logic [N*DW-1:0] req_data_i;
  logic [N-1:0]  req_last_i;
  logic [N-1:0]  req_ready_o;
  logic          tx_start_o;
  logic [DW-1:0] tx_data_o;
  logic          tx_done_i;
  logic [1:0]    grant_o;
  logic          busy_o;
  logic          err_o;

  logic       stubDone, txLine, stubStuck, forceBusy;
  logic       stubPending, stubActive;
  logic [9:0] stubFrame;
  int         stubBit, stubCyc;

  logic       vld[N];
  logic [7:0] dat[N];
  logic       lst[N];
  int         mPtr, mLock;
  int         vectors = 0;
  int         miscompares = 0;

  uart_tx_arbiter #(
    .DATAWIDTH(DW), .NUM_REQ(N), .BUSY_TIMEOUT(BT)
  ) dut (
    .clk(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_last_i(req_last_i), .req_ready_o(req_ready_o), .tx_start_o(tx_start_o),
    .tx_data_o(tx_data_o), .tx_done_i(tx_done_i), .grant_o(grant_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  assign tx_done_i = stubDone & ~forceBusy;

  // Serializer stub: done stays high one cycle after start, then a 10-bit frame.
  always @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      stubDone <= 1'b1; txLine <= 1'b1; stubPending <= 1'b0; stubActive <= 1'b0;
      stubFrame <= '1; stubBit <= 0; stubCyc <= 0;
    end else begin
      if (tx_start_o && !stubStuck) begin
        stubPending <= 1'b1;
        stubFrame   <= {1'b1, tx_data_o, 1'b0};
      end
      if (stubPending) begin
        stubPending <= 1'b0; stubActive <= 1'b1; stubDone <= 1'b0;
        txLine <= stubFrame[0]; stubBit <= 0; stubCyc <= 0;
      end else if (stubActive) begin
        if (stubCyc == CPB - 1) begin
          stubCyc <= 0;
          if (stubBit == 9) begin
            stubActive <= 1'b0; stubDone <= 1'b1; txLine <= 1'b1;
          end else begin
            stubBit <= stubBit + 1;
            txLine  <= stubFrame[stubBit + 1];
          end
        end else begin
          stubCyc <= stubCyc + 1;
        end
      end
    end
  end

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_valid_i[i]        = vld[i];
      req_data_i[i*DW +: DW] = dat[i];
      req_last_i[i]         = lst[i];
    end
  endtask

  function automatic int model_pick();
    for (int k = 1; k <= N; k++) begin
      int idx = (mPtr + k) % N;
      if (vld[idx] && (mLock < 0 || mLock == idx)) return idx;
    end
    return -1;
  endfunction

  task automatic model_accept(input int w);
    mPtr  = w;
    mLock = lst[w] ? -1 : w;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      vld[i] = 1'b0; dat[i] = 8'h00; lst[i] = 1'b1;
    end
    drive_reqs();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    stubStuck = 1'b0;
    forceBusy = 1'b0;
    clear_reqs();
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    mPtr  = N - 1;
    mLock = -1;
  endtask

  task automatic wait_ready(input int maxCyc, output logic ok, output logic [N-1:0] rdy);
    ok = 1'b0; rdy = '0;
    for (int i = 0; i < maxCyc; i++) begin
      #1;
      if (|req_ready_o) begin
        ok = 1'b1; rdy = req_ready_o;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int maxCyc, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < maxCyc; i++) begin
      @(negedge clk);
      if (!busy_o) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    for (int i = 0; i < N; i++) begin
      vld[i] = 1'b1; dat[i] = 8'hFF; lst[i] = 1'b1;
    end
    drive_reqs();
    @(negedge clk);
    vectors += 6;
    if (req_ready_o !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_ready: got %b expected 0000", req_ready_o); end
    if (tx_start_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_start: got %b expected 0", tx_start_o); end
    if (tx_data_o !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_data: got %h expected 00", tx_data_o); end
    if (grant_o !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_grant: got %0d expected 0", grant_o); end
    if (busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); end
    if (err_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err: got %b expected 0", err_o); end
    clear_reqs();
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic test_single();
    logic ok; logic [N-1:0] rdy;
    logic samp[128];
    int n, s, starts, readies;
    logic sawLow, dropped;
    logic [7:0] got;
    do_reset();
    vld[0] = 1'b1; dat[0] = 8'hA5; lst[0] = 1'b1;
    drive_reqs();
    wait_ready(20, ok, rdy);
    vectors += 2;
    if (!ok) begin miscompares++; $display("[TB] FAIL single_grant_wait: got none expected grant within 20 cycles"); end
    if (rdy !== 4'b0001) begin miscompares++; $display("[TB] FAIL single_ready: got %b expected 0001", rdy); end
    @(negedge clk);
    vectors += 2;
    if (tx_start_o !== 1'b1) begin miscompares++; $display("[TB] FAIL single_start: got %b expected 1", tx_start_o); end
    if (tx_data_o !== 8'hA5) begin miscompares++; $display("[TB] FAIL single_data: got %h expected a5", tx_data_o); end
    vld[0] = 1'b0;
    drive_reqs();
    n = 0; starts = 0; readies = 0; sawLow = 1'b0; dropped = 1'b0;
    while (n < 128) begin
      @(negedge clk);
      if (!busy_o) begin dropped = 1'b1; break; end
      samp[n] = txLine;
      if (tx_start_o) starts++;
      if (|req_ready_o) readies++;
      if (!tx_done_i) sawLow = 1'b1;
      n++;
    end
    vectors += 4;
    if (!dropped) begin miscompares++; $display("[TB] FAIL single_busy_drop: got busy stuck expected release"); end
    if (!sawLow || !tx_done_i) begin miscompares++; $display("[TB] FAIL single_busy_span: got sawLow=%b done=%b expected 1/1", sawLow, tx_done_i); end
    if (starts != 0) begin miscompares++; $display("[TB] FAIL single_extra_start: got %0d expected 0", starts); end
    if (readies != 0) begin miscompares++; $display("[TB] FAIL single_extra_ready: got %0d expected 0", readies); end
    s = -1;
    for (int i = 0; i < n; i++) if (s < 0 && samp[i] === 1'b0) s = i;
    got = 8'h00;
    if (s >= 0 && s + 4*8 + 2 < n)
      for (int i = 0; i < 8; i++) got[i] = samp[s + 4*(i+1) + 2];
    vectors++;
    if (got !== 8'hA5) begin miscompares++; $display("[TB] FAIL single_line_frame: got %h expected a5", got); end
  endtask

  task automatic test_round_robin();
    int expIdx[6] = '{0, 1, 2, 0, 1, 2};
    logic ok; logic [N-1:0] rdy;
    do_reset();
    for (int i = 0; i < 3; i++) begin vld[i] = 1'b1; lst[i] = 1'b1; end
    dat[0] = 8'h10; dat[1] = 8'h21; dat[2] = 8'h32;
    drive_reqs();
    for (int r = 0; r < 6; r++) begin
      wait_ready(60, ok, rdy);
      vectors++;
      if (rdy !== (4'b0001 << expIdx[r])) begin miscompares++; $display("[TB] FAIL rr_ready[%0d]: got %b expected idx %0d", r, rdy, expIdx[r]); end
      @(negedge clk);
      vectors += 2;
      if (tx_data_o !== dat[expIdx[r]]) begin miscompares++; $display("[TB] FAIL rr_data[%0d]: got %h expected %h", r, tx_data_o, dat[expIdx[r]]); end
      if (grant_o !== 2'(expIdx[r])) begin miscompares++; $display("[TB] FAIL rr_grant[%0d]: got %0d expected %0d", r, grant_o, expIdx[r]); end
      wait_idle(80, ok);
    end
  endtask

  task automatic test_lock();
    int         expIdx[5]  = '{0, 1, 1, 1, 0};
    logic [7:0] expData[5] = '{8'h55, 8'h01, 8'h02, 8'h03, 8'h55};
    logic [7:0] b1[3] = '{8'h01, 8'h02, 8'h03};
    logic       l1[3] = '{1'b0, 1'b0, 1'b1};
    int  p1;
    logic ok; logic [N-1:0] rdy;
    do_reset();
    vld[0] = 1'b1; dat[0] = 8'h55; lst[0] = 1'b1;
    p1 = 0;
    vld[1] = 1'b1; dat[1] = b1[0]; lst[1] = l1[0];
    drive_reqs();
    for (int r = 0; r < 5; r++) begin
      wait_ready(60, ok, rdy);
      vectors++;
      if (rdy !== (4'b0001 << expIdx[r])) begin miscompares++; $display("[TB] FAIL lock_ready[%0d]: got %b expected idx %0d", r, rdy, expIdx[r]); end
      @(negedge clk);
      vectors++;
      if (tx_data_o !== expData[r]) begin miscompares++; $display("[TB] FAIL lock_data[%0d]: got %h expected %h", r, tx_data_o, expData[r]); end
      if (rdy[1]) begin
        p1++;
        if (p1 < 3) begin dat[1] = b1[p1]; lst[1] = l1[p1]; end
        else vld[1] = 1'b0;
        drive_reqs();
      end
      wait_idle(80, ok);
    end
  endtask

  task automatic test_timeout();
    int errCount, errAt;
    logic busyAfter;
    logic ok; logic [N-1:0] rdy;
    do_reset();
    stubStuck = 1'b1;
    vld[2] = 1'b1; dat[2] = 8'h3C; lst[2] = 1'b0;
    drive_reqs();
    wait_ready(20, ok, rdy);
    vectors++;
    if (rdy !== 4'b0100) begin miscompares++; $display("[TB] FAIL to_ready: got %b expected 0100", rdy); end
    @(negedge clk);
    vld[2] = 1'b0;
    drive_reqs();
    errCount = 0; errAt = -1; busyAfter = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (err_o) begin errCount++; if (errAt < 0) errAt = c; end
      if (c == BT + 2) busyAfter = busy_o;
    end
    vectors += 3;
    if (errCount != 1) begin miscompares++; $display("[TB] FAIL to_err_count: got %0d expected 1", errCount); end
    if (errAt != BT + 1) begin miscompares++; $display("[TB] FAIL to_err_cycle: got %0d expected %0d", errAt, BT + 1); end
    if (busyAfter !== 1'b0) begin miscompares++; $display("[TB] FAIL to_back_idle: got busy=%b expected 0", busyAfter); end
    stubStuck = 1'b0;
    vld[0] = 1'b1; dat[0] = 8'h77; lst[0] = 1'b1;
    drive_reqs();
    wait_ready(20, ok, rdy);
    vectors++;
    if (rdy !== 4'b0001) begin miscompares++; $display("[TB] FAIL to_lock_cleared: got %b expected 0001", rdy); end
    @(negedge clk);
    vld[0] = 1'b0;
    drive_reqs();
    wait_idle(80, ok);
  endtask

  task automatic test_reset_midframe();
    logic ok; logic [N-1:0] rdy;
    int guard;
    do_reset();
    for (int i = 0; i < N; i++) begin vld[i] = 1'b1; dat[i] = 8'h90 + 8'(i); lst[i] = 1'b1; end
    drive_reqs();
    wait_ready(20, ok, rdy);
    @(negedge clk);
    wait_idle(80, ok);
    wait_ready(20, ok, rdy);
    @(negedge clk);
    guard = 0;
    while (tx_done_i && guard < 10) begin @(negedge clk); guard++; end
    repeat (3) @(negedge clk);
    #2 rst_i = 1'b1;
    #1;
    vectors += 6;
    if (req_ready_o !== 4'b0000) begin miscompares++; $display("[TB] FAIL mid_ready: got %b expected 0000", req_ready_o); end
    if (tx_start_o !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_start: got %b expected 0", tx_start_o); end
    if (tx_data_o !== 8'h00) begin miscompares++; $display("[TB] FAIL mid_data: got %h expected 00", tx_data_o); end
    if (grant_o !== 2'd0) begin miscompares++; $display("[TB] FAIL mid_grant: got %0d expected 0", grant_o); end
    if (busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_busy: got %b expected 0", busy_o); end
    if (err_o !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_err: got %b expected 0", err_o); end
    @(negedge clk);
    rst_i = 1'b0;
    mPtr = N - 1; mLock = -1;
    wait_ready(20, ok, rdy);
    vectors++;
    if (rdy !== 4'b0001) begin miscompares++; $display("[TB] FAIL mid_first_grant: got %b expected 0001", rdy); end
    @(negedge clk);
    clear_reqs();
    wait_idle(80, ok);
  endtask

  task automatic test_not_ready();
    logic ok;
    do_reset();
    forceBusy = 1'b1;
    vld[3] = 1'b1; dat[3] = 8'hC3; lst[3] = 1'b1;
    drive_reqs();
    for (int c = 0; c < 6; c++) begin
      #1;
      vectors++;
      if (req_ready_o !== 4'b0000) begin miscompares++; $display("[TB] FAIL nr_blocked[%0d]: got %b expected 0000", c, req_ready_o); end
      @(negedge clk);
    end
    forceBusy = 1'b0;
    #1;
    vectors++;
    if (req_ready_o !== 4'b1000) begin miscompares++; $display("[TB] FAIL nr_first_grant: got %b expected 1000", req_ready_o); end
    @(negedge clk);
    vectors += 3;
    if (tx_start_o !== 1'b1) begin miscompares++; $display("[TB] FAIL nr_start: got %b expected 1", tx_start_o); end
    if (tx_data_o !== 8'hC3) begin miscompares++; $display("[TB] FAIL nr_data: got %h expected c3", tx_data_o); end
    if (grant_o !== 2'd3) begin miscompares++; $display("[TB] FAIL nr_grant: got %0d expected 3", grant_o); end
    clear_reqs();
    wait_idle(80, ok);
  endtask

  task automatic test_random();
    logic ok; logic [N-1:0] rdy;
    int w, any;
    do_reset();
    for (int i = 0; i < N; i++) begin
      vld[i] = 1'($urandom_range(0, 1)); dat[i] = 8'($urandom); lst[i] = 1'($urandom_range(0, 1));
    end
    for (int r = 0; r < 40; r++) begin
      any = 0;
      for (int i = 0; i < N; i++) if (vld[i]) any = 1;
      if (!any) vld[$urandom_range(0, N-1)] = 1'b1;
      drive_reqs();
      w = model_pick();
      wait_ready(60, ok, rdy);
      vectors++;
      if (!ok || rdy !== (4'b0001 << w)) begin miscompares++; $display("[TB] FAIL rand_ready[%0d]: got %b expected idx %0d", r, rdy, w); end
      @(negedge clk);
      vectors += 2;
      if (tx_data_o !== dat[w]) begin miscompares++; $display("[TB] FAIL rand_data[%0d]: got %h expected %h", r, tx_data_o, dat[w]); end
      if (grant_o !== 2'(w)) begin miscompares++; $display("[TB] FAIL rand_grant[%0d]: got %0d expected %0d", r, grant_o, w); end
      model_accept(w);
      vld[w] = 1'($urandom_range(0, 1)); dat[w] = 8'($urandom); lst[w] = 1'($urandom_range(0, 1));
      if (mLock >= 0) vld[mLock] = 1'b1;
      drive_reqs();
      wait_idle(80, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("[TB] FAIL rand_idle[%0d]: got busy expected idle within 80 cycles", r); end
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish expected completion");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1;
    stubStuck = 1'b0;
    forceBusy = 1'b0;
    mPtr = N - 1;
    mLock = -1;
    clear_reqs();
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_timeout();
    test_reset_midframe();
    test_not_ready();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
